// File: rtl/class_fifo.sv
// rtl/class_fifo.sv - per-class 8-deep receive FIFO with count-decoded flags and error strobes.
// Define CLASS_FIFO_STICKY_ERR_EN to make err_overflow/err_underflow sticky until reset.
module class_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf_now;
  logic                  udf_now;

  // A pop on a full FIFO frees a slot in the same cycle, so the push is still taken.
  always_comb begin
    rd_en   = pop && !empty;
    wr_en   = push && (!full || rd_en);
    ovf_now = push && full && !rd_en;
    udf_now = pop && empty;
  end

  always_comb begin
    full         = (count == FULL_CNT);
    empty        = (count == '0);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
    fifo_count   = count;
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && reset_L) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
`ifdef CLASS_FIFO_STICKY_ERR_EN
      err_overflow  <= err_overflow | ovf_now;
      err_underflow <= err_underflow | udf_now;
`else
      err_overflow  <= ovf_now;
      err_underflow <= udf_now;
`endif
    end
  end

endmodule

// File: tb/tb_class_fifo.sv
// tb/tb_class_fifo.sv - scoreboard testbench for class_fifo.
module tb_class_fifo;

`ifdef CLASS_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        reset_L;
  logic        push;
  logic [11:0] data_in;
  logic        pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        err_overflow;
  logic        err_underflow;
  logic [3:0]  fifo_count;

  class_fifo dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] model[$];
  logic [11:0] exp_q[$];
  logic [11:0] last_data;
  logic        exp_ovf;
  logic        exp_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model.delete();
    exp_q.delete();
    last_data = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic check_flags();
    check("count", 32'(fifo_count), 32'(model.size()));
    check("full", 32'(full), 32'(model.size() == 8));
    check("empty", 32'(empty), 32'(model.size() == 0));
    check("almost_full", 32'(almost_full), 32'(model.size() >= 6));
    check("almost_empty", 32'(almost_empty), 32'(model.size() <= 2));
    check("err_overflow", 32'(err_overflow), 32'(exp_ovf));
    check("err_underflow", 32'(err_underflow), 32'(exp_udf));
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input logic p, input logic [11:0] d, input logic q);
    int   n;
    logic rd_ok;
    logic wr_ok;
    logic ovf;
    logic udf;
    push    = p;
    data_in = d;
    pop     = q;
    n       = model.size();
    rd_ok   = q && (n > 0);
    wr_ok   = p && ((n < 8) || rd_ok);
    ovf     = p && (n == 8) && !rd_ok;
    udf     = q && (n == 0);
    if (rd_ok) exp_q.push_back(model.pop_front());
    if (wr_ok) model.push_back(d);
    exp_ovf = STICKY ? (exp_ovf | ovf) : ovf;
    exp_udf = STICKY ? (exp_udf | udf) : udf;
    @(posedge clk);
    #1;
    check("valid_out", 32'(valid_out), 32'(rd_ok));
    if (rd_ok && exp_q.size() > 0) last_data = exp_q.pop_front();
    check("data_out", 32'(data_out), 32'(last_data));
    check_flags();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    reset_L = 1'b0;
    push    = 1'b1;
    data_in = 12'hABC;
    pop     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check_flags();
    push    = 1'b0;
    reset_L = 1'b1;
    step(1'b0, 12'h000, 1'b0);

    for (int i = 1; i <= 8; i++) step(1'b1, 12'(i), 1'b0);
    step(1'b1, 12'h0FF, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    step(1'b1, 12'h009, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 12'h000, 1'b1);

    step(1'b0, 12'h000, 1'b1);
    step(1'b1, 12'h3A5, 1'b1);
    step(1'b0, 12'h000, 1'b1);
    step(1'b0, 12'h000, 1'b0);

    step(1'b1, 12'($urandom), 1'b0);
    step(1'b1, 12'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 12'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom), 1'b0);
    check("pre_reset_count", 32'(fifo_count), 32'd5);

    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check("async_valid_out", 32'(valid_out), 32'd0);
    check("async_data_out", 32'(data_out), 32'd0);
    check_flags();
    @(negedge clk);
    reset_L = 1'b1;
    step(1'b0, 12'h000, 1'b1);
    step(1'b0, 12'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/class_fifo.md
Name: class_fifo

Overview:
- Per-class receive FIFO that sits directly downstream of the 4-way class demux.
- Four instances are used, one per class; each consumes one demux output pair (push_N, data_out_N) and buffers 12-bit words until the egress stage pops them.
- Provides full/empty and programmable almost-full/almost-empty flags for upstream flow control and egress arbitration.

Parameters:
- DATA_WIDTH, 12, word width; matches the demux data path.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8 words.
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_L  input  1  reset, asynchronous assert, active-low.
- push  input  1  write strobe, driven from the demux push_N.
- data_in  input  DATA_WIDTH  write data, driven from the demux data_out_N.
- pop  input  1  read request from the egress stage.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out carries a freshly popped word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- err_overflow  output  1  push was rejected because the FIFO was full.
- err_underflow  output  1  pop was rejected because the FIFO was empty.
- fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (reset_L low clears state immediately). Release is sampled on the next clk rising edge.
- Reset values:
  - wr_ptr, rd_ptr and count = 0.
  - data_out = 0, valid_out = 0, err_overflow = 0, err_underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared.
- Storage: DEPTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. count is a separate ADDR_WIDTH+1 register.
- Flags: combinational decode of the registered count only, so they are glitch-free and valid in the same cycle as fifo_count.
- Write:
  - Accepted when push=1 and (full=0, or pop is also valid in the same cycle).
  - mem[wr_ptr] <= data_in; wr_ptr increments.
- Read:
  - Valid when pop=1 and empty=0.
  - data_out <= mem[rd_ptr]; rd_ptr increments; valid_out=1 in the following cycle.
  - Read latency is one cycle from pop to data_out/valid_out.
  - With no valid pop, valid_out=0 and data_out holds its last value.
- Count update: +1 on accepted write only; -1 on valid read only; unchanged when both or neither occur.
- Boundary cases:
  - Full, push and pop together: both performed, count stays DEPTH, no error.
  - Full, push only: write dropped, memory and pointers untouched, err_overflow=1 next cycle.
  - Empty, push and pop together: pop is invalid (err_underflow=1), push is accepted, count goes to 1, valid_out=0. Reads are never forwarded combinationally from write to read.
  - Empty, pop only: err_underflow=1, data_out holds, valid_out=0.
  - Pointer wrap is transparent: 20 sequential push/pop pairs return data in exact FIFO order.
- Error flags: without the optional feature, each flag is a one-cycle pulse registered in the cycle after the offending request.
- Reset mid-operation: all state is discarded immediately, with no partial writes; the FIFO reads empty after release.

Optional Feature:
- Macro: CLASS_FIFO_STICKY_ERR_EN.
- Defined: err_overflow and err_underflow are sticky. Once set they stay 1 until reset_L is asserted; further errors have no additional effect.
- Not defined: both flags are single-cycle pulses, one per offending cycle. Consecutive offending cycles give a continuous high.
- Data path and other flags are identical in both builds.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with push=1, data_in=12'hABC -> empty=1, full=0, fifo_count=0, data_out=0, valid_out=0, errors 0; nothing stored after release.
- Fill/drain: push 12'h001..12'h008 on 8 consecutive cycles -> almost_full rises when fifo_count=6, full=1 at count 8. Then pop 8 times -> data_out 001..008 in order, each one cycle after its pop; almost_empty rises at count 2, empty=1 at 0.
- Overflow: when full, push 12'h0FF -> err_overflow pulses one cycle (stays high with CLASS_FIFO_STICKY_ERR_EN); count stays 8; later pops never return 0FF.
- Underflow and simultaneous on empty: when empty, pop only -> err_underflow=1, valid_out=0. Then push=1, pop=1, data_in=12'h3A5 -> err_underflow=1, fifo_count=1; next pop returns 3A5.
- Full with simultaneous push/pop: when full with 001..008, push 12'h009 and pop together -> data_out=001, count stays 8, no error. Draining returns 002..009.
- Wrap and reset mid-operation: run 20 interleaved push/pop pairs with random 12-bit data -> order preserved across wrap. Then at count 5, pulse reset_L low mid-cycle -> outputs clear immediately, and a following pop gives err_underflow.
